// File: rtl/m65c02_lst_seq.sv
// Source-select transfer sequencer: latches one W-bit source, presents it on Out,
// then streams it out as one or two byte beats on a DO/DV/Ack handshake.
module m65c02_lst_seq #(
   parameter int W    = 16,
   parameter int NSRC = 8,
   parameter int SW   = 3
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              En,
   input  logic [SW-1:0]     OSel,
   input  logic              Siz,
   input  logic [NSRC*W-1:0] Src,
   input  logic              Ack,
   output logic [W-1:0]      Out,
   output logic              Val,
   output logic [7:0]        DO,
   output logic              DV,
   output logic              Last,
   output logic              Rdy
);

   typedef enum logic [1:0] {IDLE, LO, HI} state_t;

   // High-byte offset; collapses to 0 in an 8-bit build where HI is unreachable.
   localparam int HB = (W > 8) ? 8 : 0;

   state_t         state;
   logic           siz_in, siz_q;
   logic [W-1:0]   raw, cap;
   logic           unused_slot0;

   assign siz_in       = (W > 8) ? Siz : 1'b0;
   assign unused_slot0 = ^Src[W-1:0];
   assign Rdy          = (state == IDLE);

   // Slot 0 and out-of-range selects fall through to the zero default.
   always_comb begin
      raw = '0;
      for (int k = 1; k < NSRC; k++)
         if (int'(OSel) == k) raw = Src[k*W +: W];
      cap = siz_in ? raw : (raw & W'(8'hFF));
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         Out   <= '0;
         Val   <= 1'b0;
         DO    <= '0;
         DV    <= 1'b0;
         Last  <= 1'b0;
         siz_q <= 1'b0;
      end else begin
         Val <= 1'b0;
         case (state)
            IDLE: if (En) begin
               Out   <= cap;
               Val   <= 1'b1;
               siz_q <= siz_in;
               DO    <= cap[7:0];
               DV    <= 1'b1;
               Last  <= ~siz_in;
               state <= LO;
            end
            LO: if (Ack) begin
               if (siz_q) begin
                  DO    <= Out[HB +: 8];
                  Last  <= 1'b1;
                  state <= HI;
               end else begin
                  DV    <= 1'b0;
                  Last  <= 1'b0;
                  state <= IDLE;
               end
            end
            HI: if (Ack) begin
               DV    <= 1'b0;
               Last  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/m65c02_lst_seq.md
M65C02_LST_SEQ -- requirements
Module: m65c02_lst_seq

Interface
REQ-001 Parameter W, default 16, data path width in bits; legal values 8 or 16.
REQ-002 Parameter NSRC, default 8, number of source slots including slot 0; legal range 2..16.
REQ-003 Parameter SW, default 3, select width; SHALL equal ceil(log2(NSRC)).
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 En  input  1  request to transfer a source; sampled only when Rdy=1.
REQ-007 OSel  input  SW  source index; 0 = null source (zero), 1..NSRC-1 = Src slot.
REQ-008 Siz  input  1  0 = byte transfer, 1 = word transfer; ignored (treated 0) when W=8.
REQ-009 Src  input  NSRC*W  flattened sources; slot k occupies bits [k*W+W-1 : k*W]; slot 0 bits unused.
REQ-010 Ack  input  1  downstream accepts the current DO beat.
REQ-011 Out  output  W  registered full-width transfer result.
REQ-012 Val  output  1  one-cycle pulse: Out updated this cycle.
REQ-013 DO  output  8  byte-serial beat data.
REQ-014 DV  output  1  DO beat valid.
REQ-015 Last  output  1  current DO beat is the final beat of the transfer.
REQ-016 Rdy  output  1  block idle and able to accept En.

Function
REQ-017 States: IDLE, LO, HI; Rdy SHALL be 1 only in IDLE.
REQ-018 IDLE with En=1: capture sel = (OSel==0 or OSel>=NSRC) ? 0 : Src slot OSel; if effective Siz=0, bits [W-1:8] of the capture SHALL be zero.
REQ-019 Capture SHALL appear on Out the cycle after En accepted, with Val=1 for exactly that cycle; Out holds until next accepted En.
REQ-020 Same cycle as Val: state=LO, DV=1, DO=Out[7:0], Last=~Siz_eff.
REQ-021 LO with Ack=1: Siz_eff=1 -> HI; Siz_eff=0 -> IDLE, DV=0.
REQ-022 LO with Ack=0: hold state, DO, DV, Last unchanged.
REQ-023 HI: DV=1, DO=Out[15:8], Last=1; Ack=1 -> IDLE, DV=0; Ack=0 -> hold.
REQ-024 En while Rdy=0 SHALL be ignored, not queued; Siz/OSel/Src SHALL be latched only at acceptance.
REQ-025 Ack while DV=0 SHALL be ignored.
REQ-026 Minimum transfer: byte = 2 cycles En-to-Rdy with Ack held 1; word = 3 cycles.
REQ-027 Transfer of a null source SHALL still produce Val and all beats, with DO=0.
REQ-028 Src changes after acceptance SHALL NOT affect Out or DO.

Reset
REQ-029 Rst=1 at a clock edge SHALL force state=IDLE, Out=0, Val=0, DO=0, DV=0, Last=0, Rdy=1 on the following cycle.
REQ-030 Rst SHALL take priority over En and Ack; a transfer in LO or HI is abandoned with no further beats.
REQ-031 En asserted in the same cycle as Rst SHALL be discarded.

Verification
REQ-032 W=16; OSel=2, Siz=1, slot2=16'hA55A, En one cycle, Ack=1 -> Val pulse, Out=A55A, beats DO=5A(Last=0) then A5(Last=1), Rdy back after 3 cycles.
REQ-033 OSel=3, Siz=0, slot3=16'h1234 -> Out=0034, single beat DO=34 Last=1, no HI state.
REQ-034 OSel=0, Siz=1 -> Out=0000, Val=1, two beats DO=00.
REQ-035 Word transfer, Ack=0 for 4 cycles in LO then 1 -> DO=low byte stable for 5 cycles, then high beat; En pulses during stall produce no second Val.
REQ-036 Rst asserted while in HI -> next cycle DV=0, Out=0, Rdy=1; subsequent En transfers normally.
REQ-037 W=8, NSRC=4, Siz=1, OSel=3, slot3=8'hC3 -> treated as byte: Out=C3, single beat Last=1.
